i2s_rx: RTL and testbench
=========================

# i2s_rx

I2S receiver for the Supermic datapath: it deserializes a standard Philips-format I2S stream (bit clock, `lr_clk` word select, serial data) into parallel left/right PCM samples. It is the other end of the mic array's `i2s_out` serializer. It is used for loopback verification of the mic chain on the board, and to accept a reference audio stream from an external codec. All inputs are oversampled in the single system clock domain, and completed stereo frames are presented on a valid/ready interface.

## Interface
Parameters:
- `DATA_W`, default 16: sample width in bits. Legal range is 8..32.

Ports:
- `clk` input, 1 bit: system clock. All logic runs on its rising edge.
- `rst` input, 1 bit: synchronous reset, active-high.
- `bclk` input, 1 bit: asynchronous I2S bit clock.
- `lr_clk` input, 1 bit: asynchronous word select. 0 selects the left channel, 1 selects the right channel.
- `i2s_in` input, 1 bit: asynchronous serial data, MSB first.
- `out_ready` input, 1 bit: the consumer accepts the frame when both `out_valid` and `out_ready` are high.
- `sample_l` output, `DATA_W` bits: left sample, two's complement.
- `sample_r` output, `DATA_W` bits: right sample, two's complement.
- `out_valid` output, 1 bit: a stereo frame is held on `sample_l` and `sample_r`.
- `overrun` output, 1 bit: one-cycle pulse when a completed frame is dropped.
- `frame_err` output, 1 bit: one-cycle pulse when a channel closes with a wrong bit count. Only active when `I2S_RX_FRAME_ERR_EN` is defined.

## Operation
Input conditioning:
- `bclk`, `lr_clk` and `i2s_in` each pass through a 2-flop synchronizer.
- `rise` is asserted when synchronized `bclk` is 1 and its delayed copy is 0.
- All actions below happen only in cycles where `rise` is high.
- At each `rise`, `ws_prev` is updated from synchronized `lr_clk`.
- `ws_edge` = (synchronized `lr_clk` != `ws_prev`).

State machine, states SYNC and RUN:
- Reset enters SYNC. Bits received in SYNC are discarded.
- A `rise` with `ws_edge` moves SYNC to RUN, clears `cnt` and the shift register, and closes no channel.
- RUN stays in RUN until `rst`.

Bit capture in RUN (Philips timing: the MSB arrives on the second `rise` after the `lr_clk` transition):
- On a `rise` without `ws_edge`:
  - If `cnt` < `DATA_W`, write `i2s_in` into shift-register bit `DATA_W-1-cnt`.
  - Increment `cnt`, saturating at `DATA_W+1`.
- On a `rise` with `ws_edge`, the sampled bit is the LSB slot of the channel that is ending:
  - Capture it by the same rule as above.
  - Close the channel: the word is the shift register. It is left-aligned, so short words are zero-padded in the LSBs and bits beyond `DATA_W` are dropped.
  - Store the word to the left holding register if `ws_prev`=0, or the right holding register if `ws_prev`=1.
  - Clear `cnt` and the shift register.
- Closing the right channel completes a frame, but only if a left word was closed since the last frame completion. A right close without a preceding left close is dropped silently.

Output handshake:
- When a frame completes and (`out_valid`=0 or `out_ready`=1) in that cycle, `sample_l`/`sample_r` load from the holding registers and `out_valid` becomes 1 on the next cycle.
- When a frame completes while `out_valid`=1 and `out_ready`=0, the new frame is dropped, outputs are unchanged, and `overrun` pulses for one cycle.
- If `out_valid`=1 and `out_ready`=1 with no completion, `out_valid` clears next cycle.
- `sample_l`/`sample_r` are stable while `out_valid`=1.

## Timing
- Reset values: `sample_l`=0, `sample_r`=0, `out_valid`=0, `overrun`=0, `frame_err`=0. State is SYNC, `cnt`=0, synchronizers are 0.
- `rst` asserted mid-frame discards all partial and held data. `out_valid` is 0 the cycle after.
- Input requirement: `bclk` high and low phases are each ≥ 2 `clk` periods, so `clk` ≥ 4× the bit clock frequency.
- Latency from the `bclk` pin edge to the `rise` cycle is 2–3 `clk`.
- `out_valid` rises 1 `clk` after the `rise` that closes the right channel.
- Throughput is one stereo frame per `lr_clk` period. There are no internal stalls.

## Configuration
- `I2S_RX_FRAME_ERR_EN` defined:
  - At each channel close in RUN, `frame_err` pulses for one cycle if the closed word's bit count (captured bits, including the bit sampled at the edge) != `DATA_W`.
  - The word is still stored.
- Not defined:
  - `frame_err` is tied to 0.
  - `cnt` saturates at `DATA_W`.
  - There is no error logic.

## Test plan
- Reset then a 16-bit stereo stream, L=0x8001, R=0x7FFE, `out_ready`=1: the first frame after SYNC is discarded; every later frame gives `out_valid` for 1 cycle with `sample_l`=0x8001 and `sample_r`=0x7FFE.
- `DATA_W`=16 with 12-bit slots, L=0xABC: `sample_l`=0xABC0. With the macro defined, `frame_err` pulses at each close.
- 32-bit slots carrying 0x12345678 on L, `DATA_W`=16: `sample_l`=0x1234. With the macro, `frame_err` pulses. Without the macro, `frame_err` stays 0.
- Hold `out_ready`=0 across two frames: the first frame is held on the outputs, `overrun` pulses once at the second completion, and the outputs still show the first frame.
- Assert `rst` for 1 cycle mid-left-word with `out_valid`=1: next cycle `out_valid`=0 and the samples are 0; one full frame is discarded before valid output resumes.
- `bclk` at exactly 4 `clk` per period with random data over 100 frames: the output matches a reference model bit-exactly, with no `overrun` while `out_ready`=1.

Source files
------------

// File: rtl/i2s_rx.sv
// Philips I2S receiver: oversamples bclk/lr_clk/i2s_in on clk, emits left-aligned stereo frames on valid/ready.
// Optional `I2S_RX_FRAME_ERR_EN` adds a frame_err pulse when a channel closes with a bit count other than DATA_W.
module i2s_rx #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bclk,
  input  logic              lr_clk,
  input  logic              i2s_in,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sample_l,
  output logic [DATA_W-1:0] sample_r,
  output logic              out_valid,
  output logic              overrun,
  output logic              frame_err
);

`ifdef I2S_RX_FRAME_ERR_EN
  localparam int CNT_MAX = DATA_W + 1;
`else
  localparam int CNT_MAX = DATA_W;
`endif
  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [DATA_W-1:0] MSB_ONE = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {SYNC, RUN} state_t;

  state_t            r_state;
  logic [2:0]        r_bclk_sync;  // [0],[1] synchronizer, [2] delayed copy
  logic [1:0]        r_lr_sync;
  logic [1:0]        r_din_sync;
  logic              r_ws_prev;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_hold_l;
  logic              r_have_l;

  logic              w_rise;
  logic              w_ws_edge;
  logic [DATA_W-1:0] w_word;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_rise    = r_bclk_sync[1] & ~r_bclk_sync[2];
  assign w_ws_edge = r_lr_sync[1] != r_ws_prev;
  // Shifting the marker past the word once cnt reaches DATA_W drops surplus bits.
  assign w_word    = r_shift | ({DATA_W{r_din_sync[1]}} & (MSB_ONE >> r_cnt));
  assign w_cnt_inc = (r_cnt == CNT_W'(CNT_MAX)) ? r_cnt : r_cnt + 1'b1;

`ifndef I2S_RX_FRAME_ERR_EN
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SYNC;
      r_bclk_sync <= '0;
      r_lr_sync   <= '0;
      r_din_sync  <= '0;
      r_ws_prev   <= 1'b0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_hold_l    <= '0;
      r_have_l    <= 1'b0;
      sample_l    <= '0;
      sample_r    <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
      frame_err   <= 1'b0;
`endif
    end else begin
      r_bclk_sync <= {r_bclk_sync[1:0], bclk};
      r_lr_sync   <= {r_lr_sync[0], lr_clk};
      r_din_sync  <= {r_din_sync[0], i2s_in};
      overrun     <= 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
      frame_err   <= 1'b0;
`endif
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (w_rise) begin
        r_ws_prev <= r_lr_sync[1];
        if (r_state == SYNC) begin
          if (w_ws_edge) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_shift <= '0;
          end
        end else if (w_ws_edge) begin
          // The bit sampled at a word-select edge is the LSB slot of the closing channel.
          r_cnt   <= '0;
          r_shift <= '0;
`ifdef I2S_RX_FRAME_ERR_EN
          frame_err <= (w_cnt_inc != CNT_W'(DATA_W));
`endif
          if (r_ws_prev) begin
            if (r_have_l) begin
              r_have_l <= 1'b0;
              if (!out_valid || out_ready) begin
                sample_l  <= r_hold_l;
                sample_r  <= w_word;
                out_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else begin
            r_hold_l <= w_word;
            r_have_l <= 1'b1;
          end
        end else begin
          r_shift <= w_word;
          r_cnt   <= w_cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: drives Philips I2S streams and compares frames against an arithmetic model.
module tb_i2s_rx;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bclk = 1'b0;
  logic          lr_clk = 1'b0;
  logic          i2s_in = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] sample_l, sample_r;
  logic          out_valid, overrun, frame_err;

  int checks = 0;
  int errors = 0;
  logic [31:0]     fl[$];
  logic [31:0]     fr[$];
  logic [2*DW-1:0] acc[$];
  int n_ovr, n_ferr, n_vcyc;

  always #5 clk = ~clk;

  i2s_rx #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .bclk(bclk), .lr_clk(lr_clk), .i2s_in(i2s_in),
    .out_ready(out_ready), .sample_l(sample_l), .sample_r(sample_r),
    .out_valid(out_valid), .overrun(overrun), .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) acc.push_back({sample_l, sample_r});
      if (out_valid) n_vcyc++;
      if (overrun) n_ovr++;
      if (frame_err) n_ferr++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_obs();
    acc.delete();
    n_ovr = 0; n_ferr = 0; n_vcyc = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; bclk = 1'b0; lr_clk = 1'b0; i2s_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    clear_obs();
  endtask

  // Left-justify the low `slot` bits of w into DW bits.
  function automatic logic [DW-1:0] align(input logic [31:0] w, input int slot);
    longint m;
    m = longint'(w) & ((longint'(1) << slot) - 1);
    if (slot >= DW) m = m >> (slot - DW);
    else            m = m << (DW - slot);
    return m[DW-1:0];
  endfunction

  // lr_clk leads data by one bit period; both change while bclk is low.
  task automatic play(input int slot, input int ph);
    bit ch[$];
    bit d[$];
    logic [31:0] w;
    for (int f = 0; f < fl.size(); f++) begin
      for (int s = 0; s < 2; s++) begin
        w = s ? fr[f] : fl[f];
        for (int b = 0; b < slot; b++) begin
          ch.push_back(s[0]);
          d.push_back(w[slot-1-b]);
        end
      end
    end
    for (int p = 0; p < 4; p++) begin
      ch.push_back(1'b0);
      d.push_back(1'b0);
    end
    for (int t = 0; t < ch.size() - 1; t++) begin
      bclk = 1'b0; lr_clk = ch[t+1]; i2s_in = d[t];
      repeat (ph) tick();
      bclk = 1'b1;
      repeat (ph) tick();
    end
    bclk = 1'b0;
    repeat (2) tick();
  endtask

  task automatic fill(input int nfr, input int slot);
    fl.delete(); fr.delete();
    for (int i = 0; i < nfr; i++) begin
      fl.push_back($urandom());
      fr.push_back($urandom());
    end
  endtask

  task automatic check_frames(input string name, input int slot);
    int nexp;
    int fexp;
    logic [2*DW-1:0] e;
    nexp = fl.size() - 1;
    checks++;
    if (acc.size() !== nexp) begin
      errors++;
      $display("FAIL %s frame_count got %0d want %0d", name, acc.size(), nexp);
    end
    for (int i = 1; i <= nexp; i++) begin
      if (i - 1 < acc.size()) begin
        e = {align(fl[i], slot), align(fr[i], slot)};
        checks++;
        if (acc[i-1] !== e) begin
          errors++;
          $display("FAIL %s frame%0d got %h want %h", name, i, acc[i-1], e);
        end
      end
    end
    checks++;
    if (n_ovr !== 0) begin
      errors++;
      $display("FAIL %s overrun got %0d want 0", name, n_ovr);
    end
    checks++;
    if (n_vcyc !== acc.size()) begin
      errors++;
      $display("FAIL %s valid_cycles got %0d want %0d", name, n_vcyc, acc.size());
    end
`ifdef I2S_RX_FRAME_ERR_EN
    fexp = (slot != DW) ? 2 * fl.size() - 1 : 0;
`else
    fexp = 0;
`endif
    checks++;
    if (n_ferr !== fexp) begin
      errors++;
      $display("FAIL %s frame_err got %0d want %0d", name, n_ferr, fexp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    checks++; if (sample_l !== '0) begin errors++; $display("FAIL reset sample_l got %h want 0", sample_l); end
    checks++; if (sample_r !== '0) begin errors++; $display("FAIL reset sample_r got %h want 0", sample_r); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset overrun got %b want 0", overrun); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset frame_err got %b want 0", frame_err); end
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    fl.delete(); fr.delete();
    for (int i = 0; i < 4; i++) begin
      fl.push_back(32'h8001);
      fr.push_back(32'h7FFE);
    end
    play(16, 2);
    check_frames("basic", 16);
  endtask

  task automatic test_short_slot();
    do_reset();
    out_ready = 1'b1;
    fill(3, 12);
    for (int i = 0; i < 3; i++) fl[i] = 32'hABC;
    play(12, 2);
    check_frames("short_slot", 12);
  endtask

  task automatic test_long_slot();
    do_reset();
    out_ready = 1'b1;
    fill(3, 32);
    for (int i = 0; i < 3; i++) fl[i] = 32'h12345678;
    play(32, 2);
    check_frames("long_slot", 32);
  endtask

  task automatic test_overrun();
    logic [2*DW-1:0] e;
    do_reset();
    out_ready = 1'b0;
    fill(3, 16);
    play(16, 2);
    e = {align(fl[1], 16), align(fr[1], 16)};
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL overrun_hold valid got %b want 1", out_valid); end
    checks++; if ({sample_l, sample_r} !== e) begin errors++; $display("FAIL overrun_hold samples got %h want %h", {sample_l, sample_r}, e); end
    checks++; if (n_ovr !== 1) begin errors++; $display("FAIL overrun_pulses got %0d want 1", n_ovr); end
    out_ready = 1'b1;
    repeat (2) tick();
    checks++; if (acc.size() !== 1) begin errors++; $display("FAIL overrun_drain count got %0d want 1", acc.size()); end
    else begin
      checks++; if (acc[0] !== e) begin errors++; $display("FAIL overrun_drain frame got %h want %h", acc[0], e); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL overrun_drain valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    fill(2, 16);
    play(16, 2);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid pre_valid got %b want 1", out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid valid got %b want 0", out_valid); end
    checks++; if ({sample_l, sample_r} !== '0) begin errors++; $display("FAIL rst_mid samples got %h want 0", {sample_l, sample_r}); end
    clear_obs();
    out_ready = 1'b1;
    fill(3, 16);
    play(16, 2);
    check_frames("rst_mid_resume", 16);
  endtask

  task automatic test_random();
    do_reset();
    out_ready = 1'b1;
    fill(100, 16);
    play(16, 2);
    check_frames("random_4clk", 16);
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    fill(20, 16);
    play(16, 3);
    check_frames("back_to_back_6clk", 16);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_slot();
    test_long_slot();
    test_overrun();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
